bram_stream_reader: RTL and testbench

- Read-side controller for a coefficient BRAM bank with 1-cycle registered read latency (DATA_W x 2^ADDR_W, raddr in, dout out).
- On a start command it sweeps a contiguous address range, absorbs the read latency, and presents coefficients as a valid/ready stream with full backpressure.
- Sits between a bank and the butterfly/PE datapath or the output unloader. Sustains 1 word/cycle when the sink is always ready.

---
 rtl/bram_stream_reader_pkg.sv | 13 +
 rtl/bram_stream_reader_if.sv | 27 ++
 rtl/bram_stream_reader_stream_skid2.sv | 53 +++++
 rtl/bram_stream_reader.sv | 105 ++++++++++
 tb/tb_bram_stream_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared defaults and FSM encoding for the coefficient BRAM stream reader.
package bram_stream_reader_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready coefficient stream leaving the reader.
interface bram_stream_reader_if
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/bram_stream_reader_stream_skid2.sv
// Two-entry FIFO holding {last, data}; head is a register so the stream
// outputs never depend combinationally on the sink's ready.
module stream_skid2
    import bram_stream_reader_pkg::*;
#(
    parameter int W = DEF_DATA_W + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [1:0]   occ_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;

    assign occ  = occ_q;
    assign head = head_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) head_q <= tail_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps a contiguous BRAM address range and streams the words out with
// full backpressure, absorbing the bank's one-cycle read latency.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_m1,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] bram_dout,
    bram_stream_reader_if.master m,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic              inflight_last;
    logic              issue;
    logic              issue_ok;
    logic              final_issue;
    logic              pop;
    logic [1:0]        occ;
    logic [DATA_W:0]   head;
    logic [2:0]        load;

    assign pop      = m.m_valid & m.m_ready;
    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = head[DATA_W-1:0];
    assign m.m_last  = head[DATA_W];
    assign busy      = (state != IDLE);

    // Credit: words buffered plus the one in the bank pipe must leave room.
    assign load        = {1'b0, occ} + {2'b00, inflight};
    assign issue_ok    = load < (3'd2 + {2'b00, pop});
    assign final_issue = (remaining == {{ADDR_W{1'b0}}, 1'b1});
    assign raddr       = issue ? addr : raddr_q;

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = READ;
            end
            READ: begin
                if (issue_ok) begin
                    issue = 1'b1;
                    if (final_issue) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m.m_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            raddr_q       <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            inflight      <= issue;
            inflight_last <= issue & final_issue;
            done          <= (state == DRAIN) & pop & m.m_last;
            if (state == IDLE && start) begin
                addr      <= start_addr;
                remaining <= {1'b0, len_m1} + {{ADDR_W{1'b0}}, 1'b1};
            end else if (issue) begin
                addr      <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                remaining <= remaining - {{ADDR_W{1'b0}}, 1'b1};
                raddr_q   <= addr;
            end
        end
    end

    stream_skid2 #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight),
        .pop     (pop),
        .din     ({inflight_last, bram_dout}),
        .occ     (occ),
        .head    (head)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a behavioural 16x12 bank.
module tb_bram_stream_reader;

    localparam int DW = 12;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] len_m1 = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] bram_dout = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] mem [16];

    bram_stream_reader_if #(.DATA_W(DW)) s ();

    bram_stream_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .len_m1     (len_m1),
        .raddr      (raddr),
        .bram_dout  (bram_dout),
        .m          (s),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bram_dout <= mem[raddr];

    int            checks = 0;
    int            errors = 0;
    int            accepted = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] raddr_log[$];
    bit            bp_en = 0;
    int            bp_idx = 0;

    // Sink ready pattern 1,0,0,1,0,1 repeating when backpressure is on.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            s.m_ready = (bp_idx % 6 == 0) || (bp_idx % 6 == 3) || (bp_idx % 6 == 5);
            bp_idx++;
        end else begin
            s.m_ready = 1'b1;
        end
    end

    logic        pend_last = 1'b0;
    logic        stall = 1'b0;
    logic [DW:0] stall_word = '0;

    always @(negedge clk) begin
        logic [DW:0] w;
        if (!reset_n) begin
            pend_last = 1'b0;
            stall = 1'b0;
        end else begin
            checks++;
            if (done !== pend_last) begin
                errors++;
                $display("FAIL done_pulse got %b want %b t=%0t", done, pend_last, $time);
            end
            if (stall) begin
                checks++;
                if (s.m_valid !== 1'b1 || {s.m_last, s.m_data} !== stall_word) begin
                    errors++;
                    $display("FAIL hold_stable got v=%b %h want v=1 %h", s.m_valid,
                             {s.m_last, s.m_data}, stall_word);
                end
            end
            checks++;
            if (dut.occ > 2'd2) begin
                errors++;
                $display("FAIL occ_bound got %0d want <=2", dut.occ);
            end
            if (dut.issue) raddr_log.push_back(raddr);
            if (s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got %h want none", {s.m_last, s.m_data});
                end else begin
                    w = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== w) begin
                        errors++;
                        $display("FAIL beat got last=%b data=%0d want last=%b data=%0d",
                                 s.m_last, s.m_data, w[DW], w[DW-1:0]);
                    end
                end
                accepted++;
            end
            pend_last = s.m_valid && s.m_ready && s.m_last;
            stall = s.m_valid && !s.m_ready;
            stall_word = {s.m_last, s.m_data};
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Caller sits just after a rising edge; start is sampled on the next one.
    task automatic start_sweep(input logic [AW-1:0] sa, input logic [AW-1:0] l,
                               input bit expect_it);
        logic [AW-1:0] a;
        start = 1'b1;
        start_addr = sa;
        len_m1 = l;
        if (expect_it) begin
            for (int i = 0; i <= int'(l); i++) begin
                a = sa + AW'(i);
                exp_q.push_back({(i == int'(l)), mem[a]});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, int'(done === 1'b1), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        logic [AW-1:0] wrap_exp [4];
        for (int i = 0; i < 16; i++) mem[i] = DW'(i * 100);
        wrap_exp[0] = 4'd14;
        wrap_exp[1] = 4'd15;
        wrap_exp[2] = 4'd0;
        wrap_exp[3] = 4'd1;
        s.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_valid", int'(s.m_valid), 0);
        chk("rst_data", int'(s.m_data), 0);
        chk("rst_last", int'(s.m_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset_n = 1'b1;
        tick();

        // Full bank, sink always ready: latency and throughput.
        base = accepted;
        start_sweep(4'd0, 4'd15, 1);
        chk("full_busy", int'(busy), 1);
        chk("full_valid_e0", int'(s.m_valid), 0);
        tick();
        chk("full_valid_e1", int'(s.m_valid), 0);
        tick();
        chk("full_valid_e2", int'(s.m_valid), 1);
        chk("full_first", int'(s.m_data), 0);
        repeat (16) tick();
        chk("full_done", int'(done), 1);
        chk("full_busy_end", int'(busy), 0);
        chk("full_count", accepted - base, 16);
        tick();
        chk("full_done_once", int'(done), 0);

        // Address wrap 14,15,0,1.
        raddr_log.delete();
        start_sweep(4'd14, 4'd3, 1);
        wait_done("wrap_done", 40);
        chk("wrap_issues", raddr_log.size(), 4);
        n = (raddr_log.size() < 4) ? raddr_log.size() : 4;
        for (int i = 0; i < n; i++) chk("wrap_raddr", int'(raddr_log[i]), int'(wrap_exp[i]));
        tick();

        // Backpressure.
        base = accepted;
        bp_idx = 0;
        bp_en = 1;
        start_sweep(4'd4, 4'd7, 1);
        wait_done("bp_done", 200);
        bp_en = 0;
        chk("bp_count", accepted - base, 8);
        tick();
        tick();

        // Single word.
        base = accepted;
        start_sweep(4'd5, 4'd0, 1);
        wait_done("single_done", 20);
        chk("single_count", accepted - base, 1);
        tick();
        chk("single_done_once", int'(done), 0);
        chk("single_busy", int'(busy), 0);

        // Start while busy is ignored; start in the done cycle is taken.
        base = accepted;
        start_sweep(4'd2, 4'd5, 1);
        tick();
        start_sweep(4'd9, 4'd9, 0);
        wait_done("b2b_done1", 60);
        chk("b2b_count1", accepted - base, 6);
        start_sweep(4'd8, 4'd2, 1);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_valid_e0", int'(s.m_valid), 0);
        tick();
        chk("b2b_valid_e1", int'(s.m_valid), 0);
        tick();
        chk("b2b_valid_e2", int'(s.m_valid), 1);
        chk("b2b_first", int'(s.m_data), 800);
        wait_done("b2b_done2", 30);
        tick();

        // Async reset after three words.
        base = accepted;
        start_sweep(4'd0, 4'd15, 1);
        n = 0;
        while (accepted < base + 3 && n < 40) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", int'(accepted >= base + 3), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(s.m_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_after_done", int'(done), 0);
        base = accepted;
        start_sweep(4'd3, 4'd4, 1);
        wait_done("rst_sweep_done", 40);
        chk("rst_sweep_count", accepted - base, 5);
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
